// File: rtl/dff_bank_test_ctrl.sv
// rtl/dff_bank_test_ctrl.sv - clear/preset/pattern self-test sequencer for an async preset/clear flop bank
module dff_bank_test_ctrl #(
    parameter int              WIDTH        = 8,
    parameter int              PULSE_CYCLES = 2,
    parameter logic [WIDTH-1:0] PATTERN_A   = WIDTH'(8'h55)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] d_o,
    output logic             preset_o,
    output logic             clear_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       fail_step,
    output logic [WIDTH-1:0] fail_mask
);

    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_CHK_CLR, S_PRE, S_CHK_PRE,
        S_WR_A, S_CHK_A, S_WR_B, S_CHK_B, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_o_q, d_o_d;
    logic             preset_q, preset_d;
    logic             clear_q, clear_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       fail_step_q, fail_step_d;
    logic [WIDTH-1:0] fail_mask_q, fail_mask_d;

    logic [WIDTH-1:0] exp_val;
    logic [2:0]       step_code;
    logic             is_chk;
    logic             mismatch;

    // The check states know what the bank must hold at their closing edge.
    always_comb begin
        exp_val   = '0;
        step_code = 3'd0;
        is_chk    = 1'b1;
        case (state_q)
            S_CHK_CLR: begin exp_val = '0;         step_code = 3'd1; end
            S_CHK_PRE: begin exp_val = '1;         step_code = 3'd2; end
            S_CHK_A:   begin exp_val = PATTERN_A;  step_code = 3'd3; end
            S_CHK_B:   begin exp_val = ~PATTERN_A; step_code = 3'd4; end
            default:   is_chk = 1'b0;
        endcase
        mismatch = is_chk && (q_i != exp_val);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            d_o_q       <= '0;
            preset_q    <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_step_q <= 3'd0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_o_q       <= d_o_d;
            preset_q    <= preset_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_step_q <= fail_step_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_CLR: begin
                if (cnt_q == '0) state_d = S_CHK_CLR;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHK_CLR: begin
                if (mismatch) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PRE;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) state_d = S_CHK_PRE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHK_PRE: state_d = mismatch ? S_DONE : S_WR_A;
            S_WR_A:    state_d = S_CHK_A;
            S_CHK_A:   state_d = mismatch ? S_DONE : S_WR_B;
            S_WR_B:    state_d = S_CHK_B;
            S_CHK_B:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each flop changes exactly on
    // the edge that enters a state; d_o matches the expected value in every
    // drive and check state, keeping q quiet across the check edges.
    always_comb begin
        d_o_d       = '0;
        preset_d    = 1'b0;
        clear_d     = 1'b0;
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        pass_d      = pass_q;
        fail_step_d = fail_step_q;
        fail_mask_d = fail_mask_q;
        case (state_d)
            S_CLR:            clear_d = 1'b1;
            S_PRE:   begin    preset_d = 1'b1; d_o_d = '1; end
            S_CHK_PRE:        d_o_d = '1;
            S_WR_A, S_CHK_A:  d_o_d = PATTERN_A;
            S_WR_B, S_CHK_B:  d_o_d = ~PATTERN_A;
            default:          d_o_d = '0;
        endcase
        if (state_q == S_IDLE && start) begin
            pass_d      = 1'b0;
            fail_step_d = 3'd0;
            fail_mask_d = '0;
        end
        if (mismatch) begin
            pass_d      = 1'b0;
            fail_step_d = step_code;
            fail_mask_d = q_i ^ exp_val;
        end else if (state_q == S_CHK_B) begin
            pass_d      = 1'b1;
        end
    end

    assign d_o       = d_o_q;
    assign preset_o  = preset_q;
    assign clear_o   = clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_step = fail_step_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: doc/dff_bank_test_ctrl.md
# dff_bank_test_ctrl

Sequencer that exercises an external bank of WIDTH asynchronous preset/clear D flip-flops (instances of `dff_asyn_preset_clr` sharing one `clk`). On a start request it runs four steps in order: clear, preset, write pattern A, write pattern B. After each step it compares the bank's `q` outputs against the expected value and reports pass/fail, the failing step and the failing bits. It is the bank's only driver of `preset`, `clear` and `d`, and it guarantees those control lines are glitch-free and never asserted together.

## Interface
- `WIDTH`, 8: number of flops in the bank.
- `PULSE_CYCLES`, 2: cycles each preset/clear pulse is held; must be ≥1.
- `PATTERN_A`, 8'h55 (WIDTH bits): first write pattern. Pattern B is always `~PATTERN_A`.

Ports:
- `clk`  in  1: single clock, shared with the flop bank.
- `clear`  in  1: asynchronous, active-high reset of this controller.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `q_i`  in  WIDTH: bank outputs.
- `d_o`  out  WIDTH: bank data inputs.
- `preset_o`  out  1: bank async preset.
- `clear_o`  out  1: bank async clear.
- `busy`  out  1: sequence in progress.
- `done`  out  1: one-cycle completion pulse.
- `pass`  out  1: result of the last run.
- `fail_step`  out  3: 0 = pass/none, 1 = clear, 2 = preset, 3 = pattern A, 4 = pattern B.
- `fail_mask`  out  WIDTH: `q_i ^ expected` at the failing check; 0 on pass.

## Operation
- **Registered outputs.** Every output is driven from a flop; no combinational path to `preset_o`, `clear_o` or `d_o`, because the bank consumes these asynchronously.
- **Reset values** (while `clear`=1): state IDLE, `d_o`=0, `preset_o`=0, `clear_o`=0, `busy`=0, `done`=0, `pass`=0, `fail_step`=0, `fail_mask`=0, pulse counter 0.
- **States:** IDLE → CLR → CHK_CLR → PRE → CHK_PRE → WR_A → CHK_A → WR_B → CHK_B → DONE → IDLE.
- **IDLE:** on `start`=1, go to CLR, load counter to PULSE_CYCLES-1, clear `pass`/`fail_step`/`fail_mask`.
- **CLR:** `clear_o`=1, `d_o`=0. Counter decrements; go to CHK_CLR when counter = 0.
- **CHK_CLR:** `clear_o`=0, `d_o`=0, expected value 0.
- **PRE:** `preset_o`=1, `d_o`=all ones. Counter runs as in CLR; go to CHK_PRE when counter = 0.
- **CHK_PRE:** `preset_o`=0, `d_o`=all ones, expected value all ones.
- **WR_A:** `d_o`=PATTERN_A for 1 cycle; the bank captures it at the edge leaving WR_A.
- **CHK_A:** `d_o` held at PATTERN_A, expected value PATTERN_A.
- **WR_B / CHK_B:** as WR_A / CHK_A with `~PATTERN_A`.
- **Stable `d_o`.** `d_o` always equals the expected value in both the drive and check states, so `q` is stable through every check edge.
- **Check rule.** Each CHK state compares `q_i` with the expected value at its closing edge.
  - Mismatch: record `fail_step` and `fail_mask`, set `pass`=0, go directly to DONE.
  - Match in CHK_B: set `pass`=1.
- **DONE:** `done`=1 for one cycle, then IDLE. `d_o` returns to 0, and `preset_o`/`clear_o` are 0.
- **Result hold.** `pass`, `fail_step` and `fail_mask` hold until the next accepted `start`.
- **Invariant:** `preset_o & clear_o` = 0 in every cycle, including around reset.

## Timing
- **`busy`** is 1 from the cycle after `start` is accepted through the last CHK cycle executed; it is 0 in DONE and IDLE.
- **Full pass run:** `busy` lasts 2·PULSE_CYCLES+6 cycles; `done` follows in the next cycle. With the defaults this is 10 busy cycles, then `done`.
- **Early fail:** DONE follows the failing CHK cycle immediately, so a clear failure has `busy` for PULSE_CYCLES+1 cycles.
- **Pulse width:** each control pulse is exactly PULSE_CYCLES cycles and is followed by ≥1 cycle with both controls low.
- **`start` while busy or in DONE:** ignored, with no queuing.
- **`clear` mid-run:**
  - all outputs go to their reset values asynchronously;
  - a `preset_o`/`clear_o` pulse in progress is truncated;
  - no `done` is produced;
  - a later `start` runs the full sequence from CLR.
- **`start` and `clear` together:** `clear` wins.

## Test plan
- **Good 8-bit bank, defaults, `start` pulse** → `busy` for 10 cycles, `done` in cycle 11, `pass`=1, `fail_step`=0, `fail_mask`=0x00; `d_o` sequence is 0x00, 0xFF, 0x55, 0xAA.
- **Bank bit 3 stuck at 0** → fails at CHK_PRE: `pass`=0, `fail_step`=2, `fail_mask`=0x08, `done` after 6 busy cycles.
- **Bank bit 0 stuck at 1** → `fail_step`=1, `fail_mask`=0x01, `busy` for 3 cycles.
- **Bits 1 and 2 shorted** (bit 2 follows bit 1) → `fail_step`=3, `fail_mask`=0x04.
- **Reset and restart:** assert `clear` during PRE → `preset_o` drops immediately and all outputs are 0. `start` pulses during `busy` are ignored. A later `start` gives a full pass run of 10 busy cycles.
- **Throughout every scenario:** assert `preset_o & clear_o` = 0 every cycle, and check that each pulse width equals PULSE_CYCLES. Rerun with PULSE_CYCLES=1 and PULSE_CYCLES=5: busy lengths 8 and 16 cycles.
